seq_slice_adder: RTL
====================

# seq_slice_adder

Multi-cycle, parametrised two's-complement adder/subtractor that processes WIDTH-bit operands in SLICE-bit slices, LSB slice first, with a ripple carry held between cycles. It generalises the single-bit full-adder cell to arbitrary width, adds a subtract mode, and reports carry-out and signed overflow. It sits behind a start/busy/done handshake so datapath controllers can trade latency for area.

## Interface
- WIDTH, 32: operand and result width in bits. Must be a multiple of SLICE.
- SLICE, 8: bits added per cycle; 1 ≤ SLICE ≤ WIDTH.
- NSLICE (localparam), WIDTH/SLICE: cycles per operation.

- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled on a rising edge while IDLE or DONE.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- cin  in  1  carry-in; acts as borrow-in when sub=1. Captured with the operands.
- sub  in  1  0 = A+B+cin, 1 = A−B−cin. Captured with the operands.
- busy  out  1  high while the state is RUN.
- done  out  1  one-cycle pulse; the result is valid from this cycle on.
- sum  out  WIDTH  result; holds its value until the next completion.
- cout  out  1  carry out of the MSB; for sub, 1 means no borrow.
- ovf  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, go to RUN.
  - Capture a into opA and (sub ? ~b : b) into opB.
  - Set carry = cin XOR sub.
  - Clear the slice counter.
- RUN, one slice per cycle:
  - Form {c, s} = opA[SLICE-1:0] + opB[SLICE-1:0] + carry.
  - Shift s into the MSB end of the accumulator; shift opA and opB right by SLICE.
  - carry ← c.
  - On the last slice, also record the carry into the MSB for ovf.
  - When the counter reaches NSLICE-1, go to DONE and load sum, cout and ovf from the accumulator.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1, accept new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- start in RUN is ignored. Operands are not re-sampled.
- a, b, cin and sub may change freely after acceptance.
- sum, cout and ovf change only on the edge that enters DONE. During RUN they hold the previous result.
- Width rules:
  - Internal slice add is SLICE+1 bits.
  - cout is the carry out of bit WIDTH-1; ovf is computed on bit WIDTH-1 only.
  - Nothing wider than WIDTH is retained.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0.
- Reset is released synchronously to clk. The first start is sampled on the first edge after release.
- Latency: start is accepted at edge E0. busy=1 after E0. done=1 and the result is valid after edge E(NSLICE). done=0 after E(NSLICE+1).
- Throughput with start held high: one result every NSLICE+1 cycles.
- Reset mid-RUN aborts the operation. All outputs return to reset values immediately. No done is produced.
- Degenerate case SLICE=WIDTH: NSLICE=1, done appears one cycle after acceptance.

## Test plan
Use WIDTH=32, SLICE=8 unless stated otherwise.
1. a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 → sum=0x00000000, cout=1, ovf=0. done is high exactly 4 edges after the start edge and lasts one cycle; busy is high for cycles 1–4.
2. a=5, b=7, cin=0, sub=1 → sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 → sum=2, cout=1.
3. Signed overflow:
   - a=0x7FFFFFFF, b=1, sub=0 → sum=0x80000000, cout=0, ovf=1.
   - a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
4. Accept a=10, b=20. Pulse start with a=0xDEAD during RUN → ignored; result is 30, and the previous sum is held stable until the done edge. Hold start high through DONE → the next operation starts with no IDLE cycle.
5. Deassert rst_n after 2 RUN cycles → busy, done, sum, cout and ovf are 0 immediately and no done pulse follows. A new start after release completes correctly.
6. WIDTH=4, SLICE=1: exhaustive a, b in 0..15, cin and sub in {0,1}. Each {cout, sum} and ovf matches the arithmetic model, and done arrives 4 cycles after start.

Source files
------------

// File: rtl/seq_slice_adder.sv
// Multi-cycle two's-complement adder/subtractor that adds WIDTH-bit operands
// SLICE bits per cycle, LSB slice first, behind a start/busy/done handshake.
module seq_slice_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic [WIDTH-1:0]   acc_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;

  logic [SLICE:0]     slice_s;
  logic [WIDTH-1:0]   slice_ext_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic               msb_cin_s;

  // Slice adder plus accumulator shift; the new slice enters at the MSB end.
  always_comb begin
    slice_s     = {1'b0, opa_r[SLICE-1:0]} + {1'b0, opb_r[SLICE-1:0]}
                + {{SLICE{1'b0}}, carry_r};
    slice_ext_s = '0;
    slice_ext_s[SLICE-1:0] = slice_s[SLICE-1:0];
    acc_next_s  = (acc_r >> SLICE) | (slice_ext_s << (WIDTH - SLICE));
    // Carry into the top bit of the slice; only meaningful on the last slice.
    msb_cin_s   = slice_s[SLICE-1] ^ opa_r[SLICE-1] ^ opb_r[SLICE-1];
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      opa_r   <= '0;
      opb_r   <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            opa_r   <= a;
            opb_r   <= sub ? ~b : b;
            carry_r <= cin ^ sub;
            acc_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_next_s;
          opa_r   <= opa_r >> SLICE;
          opb_r   <= opb_r >> SLICE;
          carry_r <= slice_s[SLICE];
          if (cnt_r == LAST_CNT) begin
            sum_r   <= acc_next_s;
            cout_r  <= slice_s[SLICE];
            ovf_r   <= msb_cin_s ^ slice_s[SLICE];
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule
